// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants and types for the pipeline controller: register index and
// destination-source encodings, memory response codes, and the control bundle
// that collects every per-stage clear/stall plus redirect and fault.
package pipeline_ctrl_pkg;

  // Register file and writeback-source encodings.
  localparam int REG_IDX_W  = 5;
  localparam int DEST_SRC_W = 2;
  localparam logic [DEST_SRC_W-1:0] DEST_SRC_ALU = 2'd0;
  localparam logic [DEST_SRC_W-1:0] DEST_SRC_MEM = 2'd1;
  localparam logic [DEST_SRC_W-1:0] DEST_SRC_PC  = 2'd2;

  // Memory interface response codes.
  localparam int MEM_CODE_W = 2;
  localparam logic [MEM_CODE_W-1:0] MEM_IDLE = 2'd0;
  localparam logic [MEM_CODE_W-1:0] MEM_BUSY = 2'd1;
  localparam logic [MEM_CODE_W-1:0] MEM_DONE = 2'd2;
  localparam logic [MEM_CODE_W-1:0] MEM_ERR  = 2'd3;

  // One bundle for every control output so each FSM branch assigns it whole.
  typedef struct packed {
    logic fe_clr;
    logic id_clr;
    logic ex_clr;
    logic me_clr;
    logic wb_clr;
    logic fe_stall;
    logic id_stall;
    logic ex_stall;
    logic me_stall;
    logic redirect;
    logic fault;
  } ctrl_t;

  // Canonical output sets.
  localparam ctrl_t CTRL_NONE = '0;

  localparam ctrl_t CTRL_INIT = '{
    fe_clr: 1'b1, id_clr: 1'b1, ex_clr: 1'b1, me_clr: 1'b1, wb_clr: 1'b1,
    default: 1'b0
  };

  // Decode holds, execute gets a bubble while the load completes.
  localparam ctrl_t CTRL_LOAD_USE = '{
    fe_stall: 1'b1, id_stall: 1'b1, ex_clr: 1'b1,
    default: 1'b0
  };

  // Wrong-path instructions in decode and execute are squashed.
  localparam ctrl_t CTRL_BRANCH = '{
    redirect: 1'b1, id_clr: 1'b1, ex_clr: 1'b1,
    default: 1'b0
  };

  // Front of the pipe frozen, writeback receives bubbles.
  localparam ctrl_t CTRL_MEM_WAIT = '{
    fe_stall: 1'b1, id_stall: 1'b1, ex_stall: 1'b1, me_stall: 1'b1,
    wb_clr: 1'b1,
    default: 1'b0
  };

  localparam ctrl_t CTRL_HALT = '{
    fe_stall: 1'b1, id_stall: 1'b1, ex_stall: 1'b1, me_stall: 1'b1,
    wb_clr: 1'b1, fault: 1'b1,
    default: 1'b0
  };

  // True when a used source index is nonzero and names the given register.
  function automatic logic reg_match(input logic used,
                                     input logic [REG_IDX_W-1:0] src,
                                     input logic [REG_IDX_W-1:0] dest);
    return used && (src != '0) && (src == dest);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detector: flags when the instruction in decode reads a
// register that the load currently in execute will write.
module pipeline_ctrl_hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0]  i_id_rs1,
  input  logic [REG_IDX_W-1:0]  i_id_rs2,
  input  logic                  i_id_rs1_used,
  input  logic                  i_id_rs2_used,
  input  logic [REG_IDX_W-1:0]  i_ex_dest_reg,
  input  logic [DEST_SRC_W-1:0] i_ex_dest_src,
  output logic                  o_load_use
);

  logic ex_is_load;
  logic rs1_hit;
  logic rs2_hit;

  // Index 0 and unused operands never match; only loads create the hazard.
  always_comb begin
    ex_is_load = (i_ex_dest_src == DEST_SRC_MEM);
    rs1_hit    = reg_match(i_id_rs1_used, i_id_rs1, i_ex_dest_reg);
    rs2_hit    = reg_match(i_id_rs2_used, i_id_rs2, i_ex_dest_reg);
    o_load_use = ex_is_load && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: sequences the post-reset clear period, then arbitrates
// between memory errors, memory waits, taken branches and load-use hazards to
// produce per-stage clear/stall, fetch redirect and a sticky fault flag.
// All outputs are combinational from the state and the current inputs, so a
// memory stall or error takes effect in the same cycle it is reported.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_IDX_W-1:0]  i_id_rs1,
  input  logic [REG_IDX_W-1:0]  i_id_rs2,
  input  logic                  i_id_rs1_used,
  input  logic                  i_id_rs2_used,
  input  logic [REG_IDX_W-1:0]  i_ex_dest_reg,
  input  logic [DEST_SRC_W-1:0] i_ex_dest_src,
  input  logic                  i_ex_branch_taken,
  input  logic                  i_mem_req_valid,
  input  logic [MEM_CODE_W-1:0] i_mem_res_code,
  output logic                  o_fe_clr,
  output logic                  o_id_clr,
  output logic                  o_ex_clr,
  output logic                  o_me_clr,
  output logic                  o_wb_clr,
  output logic                  o_fe_stall,
  output logic                  o_id_stall,
  output logic                  o_ex_stall,
  output logic                  o_me_stall,
  output logic                  o_redirect,
  output logic                  o_fault,
  output logic [1:0]            o_dbg_state
);

  localparam logic [1:0] ST_INIT     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;
  localparam logic [1:0] ST_HALT     = 2'd3;

  localparam int CNT_W = $clog2(INIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             mem_err;
  logic             mem_busy;
  logic             mem_done;
  ctrl_t            run_ctrl;
  ctrl_t            ctrl;

  pipeline_ctrl_hazard_detect u_hazard_detect (
    .i_id_rs1      (i_id_rs1),
    .i_id_rs2      (i_id_rs2),
    .i_id_rs1_used (i_id_rs1_used),
    .i_id_rs2_used (i_id_rs2_used),
    .i_ex_dest_reg (i_ex_dest_reg),
    .i_ex_dest_src (i_ex_dest_src),
    .o_load_use    (load_use)
  );

  // Decode the memory response; a busy response only counts for a live request.
  always_comb begin
    mem_err  = (i_mem_res_code == MEM_ERR);
    mem_busy = i_mem_req_valid && (i_mem_res_code == MEM_BUSY);
    mem_done = (i_mem_res_code == MEM_DONE);
  end

  // Normal-flow outputs: a taken branch squashes the load-use stall, since the
  // stalled instruction is on the wrong path anyway.
  always_comb begin
    run_ctrl = CTRL_NONE;
    if (i_ex_branch_taken) begin
      run_ctrl = CTRL_BRANCH;
    end else if (load_use) begin
      run_ctrl = CTRL_LOAD_USE;
    end
  end

  // Next-state and output selection; reset forces the clear pattern directly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl    = CTRL_NONE;
    if (reset) begin
      state_d = ST_INIT;
      cnt_d   = '0;
      ctrl    = CTRL_INIT;
    end else begin
      case (state_q)
        ST_INIT: begin
          ctrl = CTRL_INIT;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (mem_err) begin
            state_d = ST_HALT;
            ctrl    = CTRL_HALT;
          end else if (mem_busy) begin
            state_d = ST_MEM_WAIT;
            ctrl    = CTRL_MEM_WAIT;
          end else begin
            ctrl = run_ctrl;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_err) begin
            state_d = ST_HALT;
            ctrl    = CTRL_HALT;
          end else if (mem_done) begin
            state_d = ST_RUN;
            ctrl    = run_ctrl;
          end else begin
            ctrl = CTRL_MEM_WAIT;
          end
        end
        ST_HALT: begin
          ctrl = CTRL_HALT;
        end
        default: begin
          state_d = ST_INIT;
          cnt_d   = '0;
          ctrl    = CTRL_INIT;
        end
      endcase
    end
  end

  // State and INIT counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Unpack the control bundle onto the ports.
  always_comb begin
    o_fe_clr    = ctrl.fe_clr;
    o_id_clr    = ctrl.id_clr;
    o_ex_clr    = ctrl.ex_clr;
    o_me_clr    = ctrl.me_clr;
    o_wb_clr    = ctrl.wb_clr;
    o_fe_stall  = ctrl.fe_stall;
    o_id_stall  = ctrl.id_stall;
    o_ex_stall  = ctrl.ex_stall;
    o_me_stall  = ctrl.me_stall;
    o_redirect  = ctrl.redirect;
    o_fault     = ctrl.fault;
    o_dbg_state = state_q;
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl. Inputs change 1 time unit after the
// rising edge and outputs are compared 1 unit later, away from the edge.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  // Expected output vectors, layout:
  // {fe_clr,id_clr,ex_clr,me_clr,wb_clr, fe_st,id_st,ex_st,me_st, redirect, fault}
  localparam logic [10:0] O_NONE = 11'b00000_0000_0_0;
  localparam logic [10:0] O_INIT = 11'b11111_0000_0_0;
  localparam logic [10:0] O_LU   = 11'b00100_1100_0_0;
  localparam logic [10:0] O_BR   = 11'b01100_0000_1_0;
  localparam logic [10:0] O_MW   = 11'b00001_1111_0_0;
  localparam logic [10:0] O_HALT = 11'b00001_1111_0_1;

  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_MW   = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  logic                  clk;
  logic                  reset;
  logic [REG_IDX_W-1:0]  id_rs1, id_rs2;
  logic                  id_rs1_used, id_rs2_used;
  logic [REG_IDX_W-1:0]  ex_dest_reg;
  logic [DEST_SRC_W-1:0] ex_dest_src;
  logic                  ex_branch_taken;
  logic                  mem_req_valid;
  logic [MEM_CODE_W-1:0] mem_res_code;
  logic fe_clr, id_clr, ex_clr, me_clr, wb_clr;
  logic fe_stall, id_stall, ex_stall, me_stall;
  logic redirect, fault;
  logic [1:0] dbg_state;
  logic [10:0] obs;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl #(.INIT_CYCLES(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .i_id_rs1          (id_rs1),
    .i_id_rs2          (id_rs2),
    .i_id_rs1_used     (id_rs1_used),
    .i_id_rs2_used     (id_rs2_used),
    .i_ex_dest_reg     (ex_dest_reg),
    .i_ex_dest_src     (ex_dest_src),
    .i_ex_branch_taken (ex_branch_taken),
    .i_mem_req_valid   (mem_req_valid),
    .i_mem_res_code    (mem_res_code),
    .o_fe_clr          (fe_clr),
    .o_id_clr          (id_clr),
    .o_ex_clr          (ex_clr),
    .o_me_clr          (me_clr),
    .o_wb_clr          (wb_clr),
    .o_fe_stall        (fe_stall),
    .o_id_stall        (id_stall),
    .o_ex_stall        (ex_stall),
    .o_me_stall        (me_stall),
    .o_redirect        (redirect),
    .o_fault           (fault),
    .o_dbg_state       (dbg_state)
  );

  assign obs = {fe_clr, id_clr, ex_clr, me_clr, wb_clr,
                fe_stall, id_stall, ex_stall, me_stall, redirect, fault};

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Benign inputs: nothing in flight, no register reads, no branch.
  task automatic drive_idle();
    id_rs1          = '0;
    id_rs2          = '0;
    id_rs1_used     = 1'b0;
    id_rs2_used     = 1'b0;
    ex_dest_reg     = '0;
    ex_dest_src     = DEST_SRC_ALU;
    ex_branch_taken = 1'b0;
    mem_req_valid   = 1'b0;
    mem_res_code    = MEM_IDLE;
  endtask

  // Reset for two edges, release, then four INIT cycles before RUN.
  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    #1;
    checks++;
    if (obs !== O_INIT) begin
      errors++;
      $display("FAIL reset_asserted: got %b want %b", obs, O_INIT);
    end
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      checks++;
      if (obs !== O_INIT || dbg_state !== S_INIT) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %b/%0d want %b/%0d", i, obs, dbg_state, O_INIT, S_INIT);
      end
    end
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== O_INIT || dbg_state !== S_INIT) begin
        errors++;
        $display("FAIL init_cycle[%0d]: got %b/%0d want %b/%0d", i, obs, dbg_state, O_INIT, S_INIT);
      end
      next_cycle();
    end
    checks++;
    if (obs !== O_NONE || dbg_state !== S_RUN) begin
      errors++;
      $display("FAIL init_to_run: got %b/%0d want %b/%0d", obs, dbg_state, O_NONE, S_RUN);
    end
  endtask

  // Load-use on rs1/rs2, index 0 exemption and unused-operand exemption.
  task automatic test_load_use();
    logic [REG_IDX_W-1:0] t_rs1[6]  = '{5'd1, 5'd0, 5'd3, 5'd7, 5'd9, 5'd4};
    logic [REG_IDX_W-1:0] t_rs2[6]  = '{5'd0, 5'd2, 5'd7, 5'd2, 5'd9, 5'd4};
    logic                 t_u1[6]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic                 t_u2[6]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [REG_IDX_W-1:0] t_dst[6]  = '{5'd1, 5'd0, 5'd7, 5'd7, 5'd9, 5'd4};
    logic [DEST_SRC_W-1:0] t_src[6] = '{DEST_SRC_MEM, DEST_SRC_MEM, DEST_SRC_MEM,
                                       DEST_SRC_MEM, DEST_SRC_ALU, DEST_SRC_PC};
    logic [10:0]          t_exp[6]  = '{O_LU, O_NONE, O_LU, O_NONE, O_NONE, O_NONE};
    for (int i = 0; i < 6; i++) begin
      drive_idle();
      id_rs1      = t_rs1[i];
      id_rs2      = t_rs2[i];
      id_rs1_used = t_u1[i];
      id_rs2_used = t_u2[i];
      ex_dest_reg = t_dst[i];
      ex_dest_src = t_src[i];
      #1;
      checks++;
      if (obs !== t_exp[i]) begin
        errors++;
        $display("FAIL load_use[%0d]: got %b want %b", i, obs, t_exp[i]);
      end
      next_cycle();
      // Bubble now in execute: the hazard must last exactly one cycle.
      ex_dest_src = DEST_SRC_ALU;
      #1;
      checks++;
      if (obs !== O_NONE || dbg_state !== S_RUN) begin
        errors++;
        $display("FAIL load_use_bubble[%0d]: got %b/%0d want %b/%0d", i, obs, dbg_state, O_NONE, S_RUN);
      end
      next_cycle();
    end
  endtask

  // Taken branch alone and coincident with a load-use hazard.
  task automatic test_branch();
    drive_idle();
    ex_branch_taken = 1'b1;
    #1;
    checks++;
    if (obs !== O_BR) begin
      errors++;
      $display("FAIL branch_alone: got %b want %b", obs, O_BR);
    end
    next_cycle();
    id_rs1      = 5'd1;
    id_rs1_used = 1'b1;
    ex_dest_reg = 5'd1;
    ex_dest_src = DEST_SRC_MEM;
    #1;
    checks++;
    if (obs !== O_BR) begin
      errors++;
      $display("FAIL branch_over_load_use: got %b want %b", obs, O_BR);
    end
    next_cycle();
    drive_idle();
    mem_res_code = MEM_DONE;
    #1;
    checks++;
    if (obs !== O_NONE || dbg_state !== S_RUN) begin
      errors++;
      $display("FAIL done_without_request: got %b/%0d want %b/%0d", obs, dbg_state, O_NONE, S_RUN);
    end
    next_cycle();
  endtask

  // BUSY for three cycles (hazards ignored), then DONE returns to RUN.
  task automatic test_mem_wait();
    logic [1:0] t_state[3] = '{S_RUN, S_MW, S_MW};
    drive_idle();
    mem_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_res_code    = MEM_BUSY;
      ex_branch_taken = (i == 1);
      id_rs1          = 5'd5;
      id_rs1_used     = (i == 2);
      ex_dest_reg     = 5'd5;
      ex_dest_src     = DEST_SRC_MEM;
      #1;
      checks++;
      if (obs !== O_MW || dbg_state !== t_state[i]) begin
        errors++;
        $display("FAIL mem_busy[%0d]: got %b/%0d want %b/%0d", i, obs, dbg_state, O_MW, t_state[i]);
      end
      next_cycle();
    end
    drive_idle();
    mem_req_valid = 1'b1;
    mem_res_code  = MEM_DONE;
    #1;
    checks++;
    if (obs !== O_NONE || dbg_state !== S_MW) begin
      errors++;
      $display("FAIL mem_done: got %b/%0d want %b/%0d", obs, dbg_state, O_NONE, S_MW);
    end
    next_cycle();
    drive_idle();
    #1;
    checks++;
    if (obs !== O_NONE || dbg_state !== S_RUN) begin
      errors++;
      $display("FAIL after_done: got %b/%0d want %b/%0d", obs, dbg_state, O_NONE, S_RUN);
    end
    next_cycle();
  endtask

  // Error while waiting halts with fault held; only reset recovers.
  task automatic test_mem_err();
    drive_idle();
    mem_req_valid = 1'b1;
    mem_res_code  = MEM_BUSY;
    #1;
    checks++;
    if (obs !== O_MW) begin
      errors++;
      $display("FAIL err_setup_busy: got %b want %b", obs, O_MW);
    end
    next_cycle();
    mem_res_code = MEM_ERR;
    #1;
    checks++;
    if (obs !== O_HALT || dbg_state !== S_MW) begin
      errors++;
      $display("FAIL mem_err: got %b/%0d want %b/%0d", obs, dbg_state, O_HALT, S_MW);
    end
    next_cycle();
    for (int i = 0; i < 10; i++) begin
      drive_idle();
      ex_branch_taken = (i[0] == 1'b1);
      mem_req_valid   = (i == 4);
      mem_res_code    = (i == 4) ? MEM_DONE : MEM_IDLE;
      #1;
      checks++;
      if (obs !== O_HALT || dbg_state !== S_HALT) begin
        errors++;
        $display("FAIL halt_hold[%0d]: got %b/%0d want %b/%0d", i, obs, dbg_state, O_HALT, S_HALT);
      end
      next_cycle();
    end
  endtask

  // Error reported directly in RUN also halts.
  task automatic test_err_in_run();
    drive_idle();
    mem_req_valid = 1'b1;
    mem_res_code  = MEM_ERR;
    ex_branch_taken = 1'b1;
    #1;
    checks++;
    if (obs !== O_HALT || dbg_state !== S_RUN) begin
      errors++;
      $display("FAIL err_in_run: got %b/%0d want %b/%0d", obs, dbg_state, O_HALT, S_RUN);
    end
    next_cycle();
    drive_idle();
    #1;
    checks++;
    if (obs !== O_HALT || dbg_state !== S_HALT) begin
      errors++;
      $display("FAIL err_in_run_sticky: got %b/%0d want %b/%0d", obs, dbg_state, O_HALT, S_HALT);
    end
    next_cycle();
  endtask

  // Reset in the middle of a memory wait discards it and replays INIT.
  task automatic test_reset_mid_wait();
    drive_idle();
    mem_req_valid = 1'b1;
    mem_res_code  = MEM_BUSY;
    next_cycle();
    checks++;
    if (dbg_state !== S_MW) begin
      errors++;
      $display("FAIL mid_wait_state: got %0d want %0d", dbg_state, S_MW);
    end
    test_reset();
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive_idle();
    next_cycle();
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_mem_err();
    test_reset();
    test_err_in_run();
    test_reset();
    test_reset_mid_wait();
    test_load_use();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
